// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc4_pkg
// Brief    : Shared types and constants for the ARC4 key-schedule block.
// Revision : 1.0 - initial release
// ============================================================================
package arc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_INIT  = 4'd1,
        ST_RD_I  = 4'd2,
        ST_CAP_I = 4'd3,
        ST_RD_J  = 4'd4,
        ST_CAP_J = 4'd5,
        ST_WR_I  = 4'd6,
        ST_WR_J  = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    // Cycles spent per i in the key-scheduling loop (RD_I .. WR_J).
    localparam int unsigned C_KSA_CYCLES = 6;

endpackage
`default_nettype wire

// File: rtl/arc4_key_sel.sv
`default_nettype none
// ============================================================================
// Module   : arc4_key_sel
// Brief    : Combinational selection of key byte sel_i (byte 0 = MSB).
// Revision : 1.0 - initial release
// ============================================================================
module arc4_key_sel #(
    parameter int KEY_BYTES = 3,
    parameter int SEL_W     = 2
) (
    input  logic [8*KEY_BYTES-1:0] key_i,
    input  logic [SEL_W-1:0]       sel_i,
    output logic [7:0]             byte_o
);

    always_comb begin
        byte_o = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (int'(sel_i) == k) begin
                byte_o = key_i[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arc4_sched.sv
`default_nettype none
// ============================================================================
// Module   : arc4_sched
// Brief    : ARC4 key schedule (S init + KSA) driving an external 1-port S-RAM.
// Revision : 1.0 - initial release
// ============================================================================
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    output logic                           rdy,
    input  logic [8*KEY_BYTES-1:0]         key,
    input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
    output logic [ADDR_W-1:0]              addr,
    output logic [7:0]                     wrdata,
    output logic                           wren,
    input  logic [7:0]                     rddata,
    output logic                           done
);

    localparam int KL_W = $clog2(KEY_BYTES+1);
    localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] C_I_LAST = '1;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        i_q, i_d, j_q, j_d;
    logic [7:0]               si_q, si_d, sj_q, sj_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [KL_W-1:0]          klen_q, klen_d;
    logic [KI_W-1:0]          kidx_q, kidx_d;

    logic [7:0]               w_kbyte;
    logic [ADDR_W-1:0]        w_jn;
    logic [KL_W-1:0]          w_klen_eff;
    logic                     w_unused_kb;

    arc4_key_sel #(
        .KEY_BYTES (KEY_BYTES),
        .SEL_W     (KI_W)
    ) u_key_sel (
        .key_i  (key_q),
        .sel_i  (kidx_q),
        .byte_o (w_kbyte)
    );

    // Key byte only contributes its low ADDR_W bits to j.
    assign w_unused_kb = ^w_kbyte;
    assign w_jn        = j_q + ADDR_W'(si_q) + ADDR_W'(w_kbyte);
    assign w_klen_eff  = (key_len == '0 || key_len > KL_W'(KEY_BYTES))
                         ? KL_W'(KEY_BYTES) : key_len;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        klen_d  = klen_q;
        kidx_d  = kidx_q;
        rdy     = 1'b0;
        done    = 1'b0;
        wren    = 1'b0;
        addr    = '0;
        wrdata  = '0;

        case (state_q)
            ST_IDLE: rdy = 1'b1;
            ST_INIT: begin
                addr   = i_q;
                wrdata = 8'(i_q);
                wren   = 1'b1;
                i_d    = i_q + ADDR_W'(1);
                if (i_q == C_I_LAST) state_d = ST_RD_I;
            end
            ST_RD_I: begin
                addr    = i_q;
                state_d = ST_CAP_I;
            end
            ST_CAP_I: begin
                si_d    = rddata;
                state_d = ST_RD_J;
            end
            ST_RD_J: begin
                addr    = w_jn;
                j_d     = w_jn;
                state_d = ST_CAP_J;
            end
            ST_CAP_J: begin
                sj_d    = rddata;
                state_d = ST_WR_I;
            end
            ST_WR_I: begin
                addr    = i_q;
                wrdata  = sj_q;
                wren    = 1'b1;
                state_d = ST_WR_J;
            end
            ST_WR_J: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
                i_d    = i_q + ADDR_W'(1);
                if (KL_W'(kidx_q) == klen_q - KL_W'(1)) kidx_d = '0;
                else                                    kidx_d = kidx_q + KI_W'(1);
                state_d = (i_q == C_I_LAST) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: begin
                rdy     = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Start may be accepted from IDLE or from the DONE cycle.
        if (rdy && en) begin
            key_d   = key;
            klen_d  = w_klen_eff;
            i_d     = '0;
            j_d     = '0;
            kidx_d  = '0;
            state_d = ST_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
            klen_q  <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            klen_q  <= klen_d;
            kidx_q  <= kidx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arc4_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc4_sched
// Brief    : Scoreboard bench for arc4_sched at N=4 and N=256 with RC4 KSA model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arc4_sched;
    import arc4_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en2 = 1'b0, rdy2, wren2, done2;
    logic [23:0] key2 = '0;
    logic [1:0]  klen2 = '0;
    logic [1:0]  addr2;
    logic [7:0]  wrdata2, rd2;
    logic [7:0]  mem2 [4];

    logic        en8 = 1'b0, rdy8, wren8, done8;
    logic [23:0] key8 = '0;
    logic [1:0]  klen8 = '0;
    logic [7:0]  addr8;
    logic [7:0]  wrdata8, rd8;
    logic [7:0]  mem8 [256];

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    arc4_sched #(.ADDR_W(2), .KEY_BYTES(3)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .key(key2), .key_len(klen2),
        .addr(addr2), .wrdata(wrdata2), .wren(wren2), .rddata(rd2), .done(done2)
    );

    arc4_sched #(.ADDR_W(8), .KEY_BYTES(3)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .rdy(rdy8), .key(key8), .key_len(klen8),
        .addr(addr8), .wrdata(wrdata8), .wren(wren8), .rddata(rd8), .done(done8)
    );

    always @(posedge clk) begin
        if (wren2) mem2[addr2] <= wrdata2;
        rd2 <= mem2[addr2];
        if (wren8) mem8[addr8] <= wrdata8;
        rd8 <= mem8[addr8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference RC4 KSA over an n-entry state; pushes the final S bytes.
    function automatic void push_ksa(input int n, input logic [23:0] k, input int kl);
        int s [256];
        int j;
        int t;
        int kb;
        int len;
        len = (kl == 0 || kl > 3) ? 3 : kl;
        j = 0;
        for (int i = 0; i < n; i++) s[i] = i;
        for (int i = 0; i < n; i++) begin
            kb = int'(k[8*(2-(i%len)) +: 8]) % n;
            j  = (j + s[i] + kb) % n;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int i = 0; i < n; i++) exp_q.push_back(8'(s[i]));
    endfunction

    task automatic run2(input logic [23:0] k, input int kl, input int en_cyc, input int rst_cyc);
        int low;
        bit fin;
        low = 0;
        fin = 1'b0;
        @(negedge clk);
        chk("rdy_before_run", 32'(rdy2), 1);
        key2  = k;
        klen2 = 2'(kl);
        en2   = 1'b1;
        if (rst_cyc == 0) push_ksa(4, k, kl);
        @(negedge clk);
        en2 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (rdy2) begin
                fin = 1'b1;
                break;
            end
            low++;
            if (c == en_cyc) begin
                en2   = 1'b1;
                key2  = 24'hFFFFFF;
                klen2 = 2'd1;
            end else begin
                en2 = 1'b0;
            end
            if (c == rst_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_rdy", 32'(rdy2), 1);
                chk("abort_wren", 32'(wren2), 0);
                chk("abort_done", 32'(done2), 0);
                chk("abort_addr", 32'(addr2), 0);
                for (int d = 0; d < 4; d++) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done2), 0);
                end
                return;
            end
            @(negedge clk);
        end
        en2 = 1'b0;
        chk("run2_finished", 32'(fin), 1);
        chk("done_pulse", 32'(done2), 1);
        chk("done_wren", 32'(wren2), 0);
        chk("rdy_low_cycles", 32'(low), 32'((C_KSA_CYCLES + 1) * 4));
        for (int i = 0; i < 4; i++) chk($sformatf("S2[%0d]", i), 32'(mem2[i]), 32'(exp_q.pop_front()));
        @(negedge clk);
        chk("done_single", 32'(done2), 0);
    endtask

    task automatic run8(input logic [23:0] k, input int kl);
        int low;
        bit fin;
        low = 0;
        fin = 1'b0;
        @(negedge clk);
        chk("rdy8_before_run", 32'(rdy8), 1);
        key8  = k;
        klen8 = 2'(kl);
        en8   = 1'b1;
        push_ksa(256, k, kl);
        @(negedge clk);
        en8 = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if (rdy8) begin
                fin = 1'b1;
                break;
            end
            low++;
            @(negedge clk);
        end
        chk("run8_finished", 32'(fin), 1);
        chk("done8_pulse", 32'(done8), 1);
        chk("rdy8_low_cycles", 32'(low), 32'((C_KSA_CYCLES + 1) * 256));
        for (int i = 0; i < 256; i++) chk($sformatf("S8[%0d]", i), 32'(mem8[i]), 32'(exp_q.pop_front()));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy2), 1);
        chk("rst_done", 32'(done2), 0);
        chk("rst_wren", 32'(wren2), 0);
        chk("rst_addr", 32'(addr2), 0);
        chk("rst_wrdata", 32'(wrdata2), 0);
        chk("rst_rdy8", 32'(rdy8), 1);
        rst = 1'b0;

        run2(24'h010203, 3, 0, 0);
        run2(24'h010203, 1, 0, 0);
        run2(24'h010203, 0, 0, 0);
        run2(24'h000000, 3, 0, 0);
        run2(24'h010203, 3, 10, 0);
        run2(24'h010203, 3, 0, 15);
        run2(24'h010203, 3, 0, 0);
        run8(24'h00033C, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
